// File: rtl/weight_seq_ctrl_pkg.sv
// rtl/weight_seq_ctrl_pkg.sv - shared states and constants for the weight sequencer
package weight_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_e;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/weight_seq_ctrl_if.sv
// rtl/weight_seq_ctrl_if.sv - ROM read port and weight FIFO write port bundle
interface weight_seq_ctrl_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] rom_address;
   logic                  rom_ce;
   logic [DATA_WIDTH-1:0] rom_q;
   logic [DATA_WIDTH-1:0] output_V_din;
   logic                  output_V_full_n;
   logic                  output_V_write;

   modport master (
      output rom_address, rom_ce, output_V_din, output_V_write,
      input  rom_q, output_V_full_n
   );

   modport slave (
      input  rom_address, rom_ce, output_V_din, output_V_write,
      output rom_q, output_V_full_n
   );
endinterface

// File: rtl/weight_seq_ctrl_skid.sv
// rtl/weight_seq_ctrl_skid.sv - 2-entry register FIFO absorbing the ROM read latency
module weight_seq_skid
   import weight_seq_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [CNT_WIDTH-1:0]  count,
   output logic [DATA_WIDTH-1:0] head
);
   logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  do_pop;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      case ({push, do_pop})
         2'b10: begin
            if (count_q == '0) begin
               head_d  = push_data;
               count_d = CNT_WIDTH'(1);
            end else if (count_q == CNT_WIDTH'(1)) begin
               tail_d  = push_data;
               count_d = CNT_WIDTH'(2);
            end
         end
         2'b01: begin
            if (count_q == CNT_WIDTH'(2)) head_d = tail_q;
            count_d = count_q - CNT_WIDTH'(1);
         end
         2'b11: begin
            // Occupancy is unchanged; the head advances to whichever word is next in order
            if (count_q == CNT_WIDTH'(1)) begin
               head_d = push_data;
            end else begin
               head_d = tail_q;
               tail_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = head_q;
endmodule

// File: rtl/weight_seq_ctrl.sv
// rtl/weight_seq_ctrl.sv - replays a coefficient ROM num_rep times into a weight FIFO
// Optional WEIGHT_SEQ_STALL_CNT_EN adds the stall_cnt back-pressure counter.
module weight_seq_ctrl
   import weight_seq_ctrl_pkg::*;
#(
   parameter int MEM_SIZE   = 1152,
   parameter int DATA_WIDTH = 16,
   parameter int REP_WIDTH  = 16
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic                 start,
   input  logic [REP_WIDTH-1:0] num_rep,
   output logic                 busy,
   output logic                 done,
`ifdef WEIGHT_SEQ_STALL_CNT_EN
   output logic [31:0]          stall_cnt,
`endif
   weight_seq_ctrl_if.master    bus
);
   localparam int AW = $clog2(MEM_SIZE);
   localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);

   seq_state_e            state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [REP_WIDTH-1:0]  rep_q, rep_d, num_rep_q, num_rep_d;
   logic                  inflight_q, inflight_d;
   logic                  zero_done_q, zero_done_d;
   logic                  issue, pop, drain_empty;
   logic [CNT_WIDTH-1:0]  skid_count;
   logic [2:0]            occupancy;
   logic [DATA_WIDTH-1:0] skid_head;

   assign pop         = (skid_count != '0) && bus.output_V_full_n;
   assign drain_empty = !inflight_q && (skid_count == '0);
   // Words already held or in flight, less the one leaving this cycle
   assign occupancy   = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, pop};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rep_d       = rep_q;
      num_rep_d   = num_rep_q;
      zero_done_d = 1'b0;
      issue       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_rep != '0) begin
                  state_d   = ST_RUN;
                  addr_d    = '0;
                  rep_d     = '0;
                  num_rep_d = num_rep;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (occupancy < 3'(SKID_DEPTH)) begin
               issue = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  addr_d = '0;
                  rep_d  = rep_q + REP_WIDTH'(1);
                  if (rep_q == num_rep_q - REP_WIDTH'(1)) state_d = ST_DRAIN;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      inflight_d = issue;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rep_q       <= '0;
         num_rep_q   <= '0;
         inflight_q  <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rep_q       <= rep_d;
         num_rep_q   <= num_rep_d;
         inflight_q  <= inflight_d;
         zero_done_q <= zero_done_d;
      end
   end

   weight_seq_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .push      (inflight_q),
      .push_data (bus.rom_q),
      .pop       (pop),
      .count     (skid_count),
      .head      (skid_head)
   );

   assign bus.rom_address    = addr_q;
   assign bus.rom_ce         = issue;
   assign bus.output_V_din   = skid_head;
   assign bus.output_V_write = (skid_count != '0);
   assign busy               = (state_q != ST_IDLE);
   assign done               = ((state_q == ST_DRAIN) && drain_empty) || zero_done_q;

`ifdef WEIGHT_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_IDLE) && start) begin
         stall_cnt_d = '0;
      end else if (bus.output_V_write && !bus.output_V_full_n && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) stall_cnt_q <= '0;
      else           stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb/tb_weight_seq_ctrl.sv - scoreboard bench for weight_seq_ctrl with MEM_SIZE=8
module tb_weight_seq_ctrl;
   localparam int MEM = 8;
   localparam int DW  = 16;
   localparam int RW  = 16;
   localparam int AW  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [RW-1:0] num_rep = '0;
   logic          busy, done;
`ifdef WEIGHT_SEQ_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   weight_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   weight_seq_ctrl #(.MEM_SIZE(MEM), .DATA_WIDTH(DW), .REP_WIDTH(RW)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .start    (start),
      .num_rep  (num_rep),
      .busy     (busy),
      .done     (done),
`ifdef WEIGHT_SEQ_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ROM holds w[i] = i+1 with one cycle of read latency
   always @(posedge clk) if (bus.rom_ce) bus.rom_q <= DW'(bus.rom_address) + 16'd1;

   bit          stall_en = 1'b0;
   logic [31:0] pat = 32'hB38D_64E5;
   int          pidx = 0;
   always @(posedge clk) begin
      #1;
      bus.output_V_full_n = stall_en ? pat[pidx] : 1'b1;
      pidx = (pidx + 1) % 32;
   end

   int n_vec = 0, n_fail = 0;
   logic [DW-1:0] exp_q[$];
   int t0 = 0, first_rel = -1, done_rel = -1, done_cnt = 0;
   int rom_ce_cnt = 0, xfer_cnt = 0, stall_seen = 0;
   int rd_total = 0, max_out = 0;
   bit prev_stall = 1'b0;
   logic [DW-1:0] prev_din = '0;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_total - xfer_cnt > max_out) max_out = rd_total - xfer_cnt;
         if (prev_stall) begin
            check("din_hold", bus.output_V_din, prev_din);
            check("write_hold", bus.output_V_write, 1);
         end
         if (bus.rom_ce) begin
            rom_ce_cnt++;
            rd_total++;
         end
         if (bus.output_V_write && bus.output_V_full_n) begin
            if (first_rel < 0) first_rel = cyc - t0;
            if (exp_q.size() == 0) begin
               check("unexpected_write", bus.output_V_din, -1);
            end else begin
               check("word", bus.output_V_din, exp_q.pop_front());
            end
            xfer_cnt++;
         end
         prev_stall = bus.output_V_write && !bus.output_V_full_n;
         prev_din   = bus.output_V_din;
         if (prev_stall) stall_seen++;
         if (done) begin
            done_rel = cyc - t0;
            done_cnt++;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rom_ce"}, bus.rom_ce, 0);
      check({tag, "_rom_address"}, bus.rom_address, 0);
      check({tag, "_write"}, bus.output_V_write, 0);
      check({tag, "_din"}, bus.output_V_din, 0);
   endtask

   task automatic begin_seq(input int nr);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_rep = RW'(nr);
      t0 = cyc;
      rom_ce_cnt = 0; xfer_cnt = 0; done_cnt = 0; first_rel = -1; done_rel = -1;
      stall_seen = 0; rd_total = 0; max_out = 0;
      for (int r = 0; r < nr; r++)
         for (int i = 0; i < MEM; i++) exp_q.push_back(DW'(i + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, (nr != 0));
   endtask

   task automatic wait_done(input int exp_rel);
      int k = 0;
      while (done_cnt == 0 && k < 500) begin
         @(posedge clk);
         k++;
      end
      if (done_cnt == 0) check("done_timeout", 0, 1);
      if (exp_rel >= 0) check("done_cycle", done_rel, exp_rel);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_pulse_count", done_cnt, 1);
      check("words_left", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // single pass, no back-pressure
      begin_seq(1);
      wait_done(11);
      check("t1_first_write", first_rel, 3);
      check("t1_rom_reads", rom_ce_cnt, 8);

      // three passes back to back
      begin_seq(3);
      wait_done(27);
      check("t2_first_write", first_rel, 3);
      check("t2_writes", xfer_cnt, 24);

      // pseudo-random back-pressure
      stall_en = 1'b1;
      begin_seq(2);
      wait_done(-1);
      stall_en = 1'b0;
      check("t3_writes", xfer_cnt, 16);
      check("t3_outstanding_le2", (max_out <= 2), 1);
      check("t3_some_stalls", (stall_seen > 0), 1);
`ifdef WEIGHT_SEQ_STALL_CNT_EN
      check("t3_stall_cnt", stall_cnt, stall_seen);
`endif

      // zero repeats
      begin_seq(0);
      wait_done(1);
      check("t4_rom_reads", rom_ce_cnt, 0);
      check("t4_writes", xfer_cnt, 0);

      // start during RUN is ignored
      begin_seq(5);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      num_rep = RW'(2);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(43);
      check("t5_writes", xfer_cnt, 40);

      // asynchronous reset after the fifth write, then restart
      begin_seq(1);
      begin
         int k = 0;
         while (xfer_cnt < 5 && k < 100) begin
            @(posedge clk);
            k++;
         end
         check("t6_reach_5_writes", xfer_cnt, 5);
      end
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrun_reset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      begin_seq(1);
      wait_done(11);
      check("t6_first_write", first_rel, 3);
      check("t6_writes", xfer_cnt, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
